// File: rtl/signed_divider_pkg.sv
// Shared widths, iteration count and FSM state encoding for the signed divider.
// Latency: none (declarations only).
// Backpressure: none.
package signed_divider_pkg;

    localparam int DIVIDEND_W = 8;
    localparam int DIVISOR_W  = 4;
    localparam int ITER_CNT   = 8;
    localparam int CNT_W      = $clog2(ITER_CNT);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

endpackage

// File: rtl/signed_divider_mag_conv.sv
// Two's-complement conditional negation; with neg tied to the sign bit it yields |din|.
// Latency: combinational.
// Backpressure: none.
module mag_conv #(
    parameter int W = 8
) (
    input  logic [W-1:0] din,
    input  logic         neg,
    output logic [W-1:0] dout
);

    // Invert-and-increment when negation is requested, otherwise pass through.
    // The most negative value maps to itself, which reads correctly as an unsigned magnitude.
    always_comb begin
        dout = din;
        if (neg) begin
            dout = ~din + W'(1);
        end
    end

endmodule

// File: rtl/signed_divider.sv
// Signed 8/4 restoring divider: quotient truncates toward zero, remainder takes dividend sign.
// Latency: start accepted at edge N, busy N+1..N+9, done from N+10 (one step per cycle).
// Backpressure: start is ignored while busy; results hold in DONE until the next accepted start.
// Optional DIV_ERR_EN build adds dz (divide by zero) and ovf (-128 / -1) flags valid with done.
module signed_divider
    import signed_divider_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder
`ifdef DIV_ERR_EN
    ,
    output logic                  dz,
    output logic                  ovf
`endif
);

    state_t                state_q;
    state_t                state_d;
    logic                  accept;

    logic [CNT_W-1:0]      cnt;
    logic [DIVIDEND_W-1:0] dvd_reg;
    logic [DIVISOR_W-1:0]  dvs_reg;
    logic [DIVISOR_W-1:0]  dvs_mag;
    logic                  res_sign;
    // qr starts as the dividend magnitude; quotient bits shift in from the bottom.
    logic [DIVIDEND_W-1:0] qr;
    logic [DIVISOR_W:0]    prem;

    logic [DIVIDEND_W-1:0] dvd_abs;
    logic [DIVISOR_W-1:0]  dvs_abs;
    logic [DIVIDEND_W-1:0] quo_signed;
    logic [DIVISOR_W-1:0]  rem_signed;

    logic [DIVISOR_W:0]    trial;
    logic [DIVISOR_W:0]    diff;
    logic                  ge;
    logic [DIVISOR_W:0]    prem_nxt;
    logic                  dz_case;
    logic                  ovf_case;
    // Stored remainder stays below the divisor magnitude, so its top bit never feeds the next trial.
    logic                  unused_prem_msb;

    assign unused_prem_msb = prem[DIVISOR_W];

    mag_conv #(.W(DIVIDEND_W)) u_dvd_abs (
        .din  (dividend),
        .neg  (dividend[DIVIDEND_W-1]),
        .dout (dvd_abs)
    );

    mag_conv #(.W(DIVISOR_W)) u_dvs_abs (
        .din  (divisor),
        .neg  (divisor[DIVISOR_W-1]),
        .dout (dvs_abs)
    );

    mag_conv #(.W(DIVIDEND_W)) u_quo_fix (
        .din  (qr),
        .neg  (res_sign),
        .dout (quo_signed)
    );

    mag_conv #(.W(DIVISOR_W)) u_rem_fix (
        .din  (prem[DIVISOR_W-1:0]),
        .neg  (dvd_reg[DIVIDEND_W-1]),
        .dout (rem_signed)
    );

    assign busy = (state_q == CALC) || (state_q == FIX);
    assign done = (state_q == DONE);

    // Special operand cases, decided from the latched operands so later input changes cannot leak in.
    assign dz_case  = (dvs_reg == '0);
    assign ovf_case = (dvd_reg == {1'b1, {(DIVIDEND_W-1){1'b0}}}) && (dvs_reg == '1);

    // One restoring step: shift the next dividend bit into the remainder, subtract if it fits.
    always_comb begin
        trial    = {prem[DIVISOR_W-1:0], qr[DIVIDEND_W-1]};
        ge       = (trial >= {1'b0, dvs_mag});
        diff     = trial - {1'b0, dvs_mag};
        prem_nxt = trial;
        if (ge) begin
            prem_nxt = diff;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and start acceptance; start only counts in IDLE or DONE.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (cnt == CNT_W'(ITER_CNT - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = DONE;
            end
            DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = CALC;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath: latch on acceptance, iterate in CALC, sign-correct into the outputs in FIX.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            dvd_reg   <= '0;
            dvs_reg   <= '0;
            dvs_mag   <= '0;
            res_sign  <= 1'b0;
            qr        <= '0;
            prem      <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (accept) begin
            cnt       <= '0;
            dvd_reg   <= dividend;
            dvs_reg   <= divisor;
            dvs_mag   <= dvs_abs;
            res_sign  <= dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
            qr        <= dvd_abs;
            prem      <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (state_q == CALC) begin
            cnt  <= cnt + CNT_W'(1);
            prem <= prem_nxt;
            qr   <= {qr[DIVIDEND_W-2:0], ge};
        end else if (state_q == FIX) begin
            // Divide by zero yields zero; -128/-1 wraps to the most negative quotient.
            if (dz_case) begin
                quotient  <= '0;
                remainder <= '0;
            end else if (ovf_case) begin
                quotient  <= {1'b1, {(DIVIDEND_W-1){1'b0}}};
                remainder <= '0;
            end else begin
                quotient  <= quo_signed;
                remainder <= rem_signed;
            end
        end
    end

`ifdef DIV_ERR_EN
    // Error flags: cleared on acceptance, published alongside the result in FIX.
    always_ff @(posedge clk) begin
        if (rst) begin
            dz  <= 1'b0;
            ovf <= 1'b0;
        end else if (accept) begin
            dz  <= 1'b0;
            ovf <= 1'b0;
        end else if (state_q == FIX) begin
            dz  <= dz_case;
            ovf <= ovf_case;
        end
    end
`endif

endmodule

// File: doc/signed_divider.md
SIGNED_DIVIDER -- requirements
Module: signed_divider

Interface
REQ-001 Parameters: none; widths come from package constants DIVIDEND_W=8 and DIVISOR_W=4.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  request pulse; sampled only in IDLE or DONE.
REQ-006 dividend  input  8  two's-complement dividend; captured on start acceptance.
REQ-007 divisor  input  4  two's-complement divisor; captured on start acceptance.
REQ-008 busy  output  1  high in CALC and FIX.
REQ-009 done  output  1  high in DONE; quotient and remainder are valid while done is high.
REQ-010 quotient  output  8  two's-complement quotient, truncated toward zero.
REQ-011 remainder  output  4  two's-complement remainder; its sign follows the dividend.

Function
REQ-012 The FSM SHALL have four states: IDLE, CALC, FIX, DONE.
REQ-013 Transitions SHALL be:
- IDLE to CALC on start.
- CALC to FIX after exactly 8 iterations.
- FIX to DONE.
- DONE to CALC on start; otherwise DONE holds.
REQ-014 On acceptance, the block SHALL latch the operands, their absolute values (8-bit and 4-bit unsigned magnitudes), and the result sign, which is the sign of dividend XOR the sign of divisor.
REQ-015 CALC SHALL perform one restoring shift-subtract step per cycle on the magnitudes, MSB of the dividend first, using a 5-bit partial remainder.
REQ-016 FIX SHALL negate the quotient magnitude when the result sign is 1, and negate the remainder magnitude when the dividend sign is 1.
REQ-017 Latency: start sampled at edge N; busy high from N+1 through N+9; done high from N+10. Acceptance-to-done is 10 cycles.
REQ-018 Results and done SHALL hold in DONE until the next accepted start; done SHALL drop on the edge that accepts it.
REQ-019 start asserted while busy SHALL be ignored; the in-flight operands and results SHALL be unaffected.
REQ-020 Divisor 0: the block SHALL use the same latency and state sequence, and produce quotient=8'h00 and remainder=4'h0.
REQ-021 Dividend -128 with divisor -1: quotient SHALL wrap to 8'h80 and remainder SHALL be 4'h0.
REQ-022 Dividend 0: the block SHALL produce quotient 0 and remainder 0 for any divisor.
REQ-023 Operand input changes after acceptance SHALL have no effect on the result.

Reset
REQ-024 rst SHALL force the FSM to IDLE, with busy=0, done=0, quotient=8'h00, remainder=4'h0, and all internal registers cleared.
REQ-025 rst SHALL take priority over start in the same cycle.
REQ-026 rst asserted mid-CALC or mid-FIX SHALL abort the operation with no done pulse.

Configuration
REQ-027 DIV_ERR_EN is defined: the block SHALL add outputs dz (1 bit, divisor was zero) and ovf (1 bit, -128/-1 case).
- Both flags are valid with done, reset to 0, and are cleared on start acceptance.
REQ-028 DIV_ERR_EN is undefined: the dz and ovf ports SHALL be absent, and data results SHALL be unchanged.

Structure
REQ-029 A shared package SHALL hold:
- DIVIDEND_W and DIVISOR_W;
- the state enum {IDLE, CALC, FIX, DONE};
- ITER_CNT=8.
REQ-030 One sub-module, mag_conv, SHALL provide parameterised two's-complement absolute value and conditional negation; it is instantiated for operand conversion and for FIX.

Verification
REQ-031 Dividend 100, divisor 7 -> quotient 8'h0E, remainder 4'h2, done at start+10.
REQ-032 Dividend -100, divisor 7 -> quotient 8'hF2, remainder 4'hE; dividend 100, divisor -7 -> quotient 8'hF2, remainder 4'h2.
REQ-033 Dividend -128, divisor -1 -> quotient 8'h80, remainder 4'h0, ovf=1 (DIV_ERR_EN); dividend 5, divisor 0 -> quotient 8'h00, remainder 4'h0, dz=1.
REQ-034 start pulsed at cycle 3 of CALC with new operands -> ignored; the first result is unchanged and done appears once.
REQ-035 rst at cycle 4 of CALC -> next cycle IDLE with all outputs 0; a following start on 100/7 gives the correct result.
REQ-036 Back-to-back start in DONE -> done drops the next cycle and the new result appears 10 cycles after acceptance.
